ram_access_scheduler: RTL and testbench

//  Owns the single byte-wide RAM port and shares it between instruction fetch, LSB load and LSB store.

---
 rtl/ram_access_scheduler_pkg.sv | 38 +++
 rtl/ram_byte_sequencer.sv | 133 +++++++++++++
 rtl/ram_access_scheduler.sv | 156 +++++++++++++++
 tb/tb_ram_access_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_scheduler_pkg.sv
// Shared encodings for the RAM access scheduler: booleans, access sizes,
// arbiter states and the helpers that size and extend byte-serial accesses.
package ram_access_scheduler_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    MS_IDLE  = 2'd0,
    MS_FETCH = 2'd1,
    MS_LOAD  = 2'd2,
    MS_STORE = 2'd3
  } ms_state_e;

  // The unused encoding 2'b11 is treated as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend_data(input logic [31:0] raw,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    case (size)
      SIZE_B:  return {{24{sgn & raw[7]}}, raw[7:0]};
      SIZE_H:  return {{16{sgn & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/ram_byte_sequencer.sv
// Byte-serial engine for the single RAM port: walks base..base+N-1, assembles
// or emits bytes little-endian, and re-synchronises the read pipe after a stall.
module ram_byte_sequencer
  import ram_access_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_rw,
  input  logic [1:0]            i_size,
  input  logic                  i_signed,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [31:0]           i_wdata,
  input  logic [7:0]            i_mem_din,
  output logic                  o_mem_wr,
  output logic [ADDR_WIDTH-1:0] o_mem_a,
  output logic [7:0]            o_mem_dout,
  output logic                  o_done,
  output logic [31:0]           o_rdata
);

  logic                  r_active;
  logic                  r_stalled;
  logic [2:0]            r_issue;
  logic [2:0]            r_cap;
  logic                  r_p1;
  logic                  r_p2;
  logic [31:0]           r_buf;
  logic                  r_mem_wr;
  logic [ADDR_WIDTH-1:0] r_mem_a;
  logic [7:0]            r_mem_dout;

  logic [2:0]            w_n;
  logic [2:0]            w_cap_inc;
  logic [31:0]           w_asm;
  logic [7:0]            w_wbyte;
  logic                  w_replay;
  logic                  w_last;

  assign w_n       = size_bytes(i_size);
  assign w_cap_inc = r_cap + 3'd1;
  assign w_asm     = r_buf | ({24'd0, i_mem_din} << {r_cap[1:0], 3'b000});
  assign w_wbyte   = 8'(i_wdata >> {r_issue[1:0], 3'b000});
  // After a stall the read pipe is stale, so the bus re-presents the oldest
  // byte not yet captured; writes simply repeat the byte already on the bus.
  assign w_replay  = r_active & r_stalled & rdy_in & ~i_rw;
  assign w_last    = i_rw ? (r_issue >= w_n) : (r_p2 & (w_cap_inc == w_n));

  assign o_done     = rdy_in & ~i_abort & ~i_start & r_active & ~r_stalled & w_last;
  assign o_rdata    = extend_data(w_asm, i_size, i_signed);
  assign o_mem_wr   = r_mem_wr & rdy_in;
  assign o_mem_a    = w_replay ? (i_base + ADDR_WIDTH'(r_cap)) : r_mem_a;
  assign o_mem_dout = r_mem_dout;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_active   <= FALSE;
      r_stalled  <= FALSE;
      r_issue    <= 3'd0;
      r_cap      <= 3'd0;
      r_p1       <= FALSE;
      r_p2       <= FALSE;
      r_buf      <= 32'd0;
      r_mem_wr   <= FALSE;
      r_mem_a    <= '0;
      r_mem_dout <= 8'd0;
    end else if (!rdy_in) begin
      if (r_active) r_stalled <= TRUE;
    end else if (i_abort) begin
      r_active  <= FALSE;
      r_stalled <= FALSE;
      r_p1      <= FALSE;
      r_p2      <= FALSE;
      r_mem_wr  <= FALSE;
    end else if (i_start) begin
      r_active   <= TRUE;
      r_stalled  <= FALSE;
      r_cap      <= 3'd0;
      r_issue    <= 3'd1;
      r_p1       <= ~i_rw;
      r_p2       <= FALSE;
      r_buf      <= 32'd0;
      r_mem_a    <= i_base;
      r_mem_wr   <= i_rw;
      r_mem_dout <= i_wdata[7:0];
    end else if (r_active) begin
      if (i_rw) begin
        if (r_stalled) begin
          r_stalled <= FALSE;
        end else if (r_issue < w_n) begin
          r_mem_a    <= i_base + ADDR_WIDTH'(r_issue);
          r_mem_dout <= w_wbyte;
          r_issue    <= r_issue + 3'd1;
        end else begin
          r_mem_wr <= FALSE;
          r_active <= FALSE;
        end
      end else if (r_stalled) begin
        // The replayed address counts as issued on this edge.
        r_stalled <= FALSE;
        r_p2      <= TRUE;
        if (w_cap_inc < w_n) begin
          r_mem_a <= i_base + ADDR_WIDTH'(w_cap_inc);
          r_issue <= w_cap_inc + 3'd1;
          r_p1    <= TRUE;
        end else begin
          r_mem_a <= i_base + ADDR_WIDTH'(r_cap);
          r_issue <= w_n;
          r_p1    <= FALSE;
        end
      end else begin
        if (r_p2) begin
          r_buf <= w_asm;
          r_cap <= w_cap_inc;
          if (w_cap_inc == w_n) r_active <= FALSE;
        end
        r_p2 <= r_p1;
        if (r_issue < w_n) begin
          r_mem_a <= i_base + ADDR_WIDTH'(r_issue);
          r_issue <= r_issue + 3'd1;
          r_p1    <= TRUE;
        end else begin
          r_p1 <= FALSE;
        end
      end
    end
  end

endmodule

// File: rtl/ram_access_scheduler.sv
// Arbiter for the byte-wide RAM port: grants store > load > fetch, drives the
// byte sequencer, and routes done/data back, flushing reads on rollback.
module ram_access_scheduler
  import ram_access_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rollback,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [7:0]            mem_dout,
  input  logic [7:0]            mem_din,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  ld_req,
  input  logic [31:0]           ld_addr,
  input  logic [1:0]            ld_size,
  input  logic                  ld_signed,
  output logic                  ld_done,
  output logic [31:0]           ld_data,
  input  logic                  st_req,
  input  logic [31:0]           st_addr,
  input  logic [1:0]            st_size,
  input  logic [31:0]           st_data,
  output logic                  st_done,
  output logic                  is_idle,
  output logic [1:0]            o_dbg_state
);

  ms_state_e             r_state;
  logic                  r_start;
  logic                  r_rw;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [31:0]           r_wdata;
  logic                  r_if_done;
  logic                  r_ld_done;
  logic                  r_st_done;
  logic [31:0]           r_if_data;
  logic [31:0]           r_ld_data;

  logic                  w_seq_done;
  logic [31:0]           w_seq_rdata;
  logic                  w_abort;
  logic                  w_unused_addr;

  // Only reads are flushed; a store that has been granted always completes.
  assign w_abort = rdy_in & rollback & ((r_state == MS_FETCH) | (r_state == MS_LOAD));
  assign w_unused_addr = ^{if_addr[31:ADDR_WIDTH], ld_addr[31:ADDR_WIDTH], st_addr[31:ADDR_WIDTH]};

  ram_byte_sequencer #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_seq (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .i_start    (r_start),
    .i_abort    (w_abort),
    .i_rw       (r_rw),
    .i_size     (r_size),
    .i_signed   (r_signed),
    .i_base     (r_base),
    .i_wdata    (r_wdata),
    .i_mem_din  (mem_din),
    .o_mem_wr   (mem_wr),
    .o_mem_a    (mem_a),
    .o_mem_dout (mem_dout),
    .o_done     (w_seq_done),
    .o_rdata    (w_seq_rdata)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= MS_IDLE;
      r_start   <= FALSE;
      r_rw      <= FALSE;
      r_size    <= SIZE_W;
      r_signed  <= FALSE;
      r_base    <= '0;
      r_wdata   <= 32'd0;
      r_if_done <= FALSE;
      r_ld_done <= FALSE;
      r_st_done <= FALSE;
      r_if_data <= 32'd0;
      r_ld_data <= 32'd0;
    end else if (rdy_in) begin
      r_start   <= FALSE;
      r_if_done <= FALSE;
      r_ld_done <= FALSE;
      r_st_done <= FALSE;
      case (r_state)
        MS_IDLE: begin
          if (st_req) begin
            r_state  <= MS_STORE;
            r_start  <= TRUE;
            r_rw     <= TRUE;
            r_size   <= st_size;
            r_signed <= FALSE;
            r_base   <= st_addr[ADDR_WIDTH-1:0];
            r_wdata  <= st_data;
          end else if (!rollback && ld_req) begin
            r_state  <= MS_LOAD;
            r_start  <= TRUE;
            r_rw     <= FALSE;
            r_size   <= ld_size;
            r_signed <= ld_signed;
            r_base   <= ld_addr[ADDR_WIDTH-1:0];
          end else if (!rollback && if_req) begin
            r_state  <= MS_FETCH;
            r_start  <= TRUE;
            r_rw     <= FALSE;
            r_size   <= SIZE_W;
            r_signed <= FALSE;
            r_base   <= if_addr[ADDR_WIDTH-1:0];
          end
        end
        MS_FETCH, MS_LOAD: begin
          if (rollback) begin
            r_state <= MS_IDLE;
          end else if (w_seq_done) begin
            r_state <= MS_IDLE;
            if (r_state == MS_FETCH) begin
              r_if_done <= TRUE;
              r_if_data <= w_seq_rdata;
            end else begin
              r_ld_done <= TRUE;
              r_ld_data <= w_seq_rdata;
            end
          end
        end
        MS_STORE: begin
          if (w_seq_done) begin
            r_state   <= MS_IDLE;
            r_st_done <= TRUE;
          end
        end
        default: r_state <= MS_IDLE;
      endcase
    end
  end

  assign if_done     = r_if_done;
  assign if_data     = r_if_data;
  assign ld_done     = r_ld_done;
  assign ld_data     = r_ld_data;
  assign st_done     = r_st_done;
  assign is_idle     = (r_state == MS_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ram_access_scheduler.sv
// Directed bench for ram_access_scheduler: a byte RAM with one-cycle read
// latency, per-scenario tasks with hand-computed expectations, one summary.
module tb_ram_access_scheduler;
  localparam int AW = 17;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, rollback;
  logic          mem_wr;
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_dout, mem_din;
  logic          if_req, if_done;
  logic [31:0]   if_addr, if_data;
  logic          ld_req, ld_signed, ld_done;
  logic [31:0]   ld_addr, ld_data;
  logic [1:0]    ld_size, st_size;
  logic          st_req, st_done;
  logic [31:0]   st_addr, st_data;
  logic          is_idle;
  logic [1:0]    o_dbg_state;

  ram_access_scheduler #(.ADDR_WIDTH(AW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rollback(rollback),
    .mem_wr(mem_wr), .mem_a(mem_a), .mem_dout(mem_dout), .mem_din(mem_din),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_signed(ld_signed),
    .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_size(st_size), .st_data(st_data),
    .st_done(st_done), .is_idle(is_idle), .o_dbg_state(o_dbg_state)
  );

  // clock / reset / RAM model
  always #5 clk_in = ~clk_in;

  logic [7:0]    ram [0:(1<<AW)-1];
  logic          tb_wr = 1'b0;
  logic [AW-1:0] tb_wa;
  logic [7:0]    tb_wd;

  always @(posedge clk_in) begin
    if (tb_wr) ram[tb_wa] <= tb_wd;
    else if (mem_wr) ram[mem_a] <= mem_dout;
    mem_din <= ram[mem_a];
  end

  int tests_run = 0;
  int tests_failed = 0;
  logic [AW-1:0] a_tr [0:31];
  logic [7:0]    d_tr [0:31];
  logic          w_tr [0:31];
  logic          other_done;

  // driver tasks
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    tb_wa = a; tb_wd = d; tb_wr = 1'b1;
    tick();
    tb_wr = 1'b0;
  endtask

  // First tick is the edge that samples the request; edges counts from there.
  task automatic run_until_done(input int sel, input int limit, output int edges);
    logic d;
    edges = -1;
    other_done = 1'b0;
    tick();
    for (int n = 1; n <= limit; n++) begin
      tick();
      a_tr[n] = mem_a; d_tr[n] = mem_dout; w_tr[n] = mem_wr;
      d = (sel == 0) ? if_done : (sel == 1) ? ld_done : st_done;
      if ((sel != 0 && if_done) || (sel != 1 && ld_done) || (sel != 2 && st_done))
        other_done = 1'b1;
      if (d) begin
        edges = n;
        break;
      end
    end
    if (sel == 0) if_req = 1'b0;
    else if (sel == 1) ld_req = 1'b0;
    else st_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; rollback = 1'b0;
    if_req = 0; if_addr = 0; ld_req = 0; ld_addr = 0; ld_size = 0; ld_signed = 0;
    st_req = 0; st_addr = 0; st_size = 0; st_data = 0;
    repeat (3) tick();
    tests_run++; if (mem_wr !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); end
    tests_run++; if (mem_a !== 17'h0) begin tests_failed++; $display("FAIL reset_mem_a: got %h expected 0", mem_a); end
    tests_run++; if (mem_dout !== 8'h0) begin tests_failed++; $display("FAIL reset_mem_dout: got %h expected 0", mem_dout); end
    tests_run++; if ({if_done, ld_done, st_done} !== 3'b000) begin tests_failed++; $display("FAIL reset_done: got %b expected 000", {if_done, ld_done, st_done}); end
    tests_run++; if ({if_data, ld_data} !== 64'h0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", {if_data, ld_data}); end
    tests_run++; if (is_idle !== 1'b1) begin tests_failed++; $display("FAIL reset_idle: got %b expected 1", is_idle); end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    int e;
    logic [AW-1:0] exp_a;
    poke(17'h100, 8'h13); poke(17'h101, 8'h05); poke(17'h102, 8'h00); poke(17'h103, 8'h00);
    if_req = 1'b1; if_addr = 32'h100;
    run_until_done(0, 20, e);
    tests_run++; if (e !== 6) begin tests_failed++; $display("FAIL fetch_latency: got %0d expected 6", e); end
    tests_run++; if (if_data !== 32'h00000513) begin tests_failed++; $display("FAIL fetch_data: got %h expected 00000513", if_data); end
    tests_run++; if (is_idle !== 1'b1) begin tests_failed++; $display("FAIL fetch_idle_in_done: got %b expected 1", is_idle); end
    for (int k = 0; k < 4; k++) begin
      exp_a = 17'h100 + AW'(k);
      tests_run++; if (a_tr[k+1] !== exp_a) begin tests_failed++; $display("FAIL fetch_addr%0d: got %h expected %h", k, a_tr[k+1], exp_a); end
    end
    tick();
  endtask

  task automatic test_priority();
    int e;
    logic [7:0] exp_b [0:3];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    st_req = 1; st_addr = 32'h200; st_size = 2'b10; st_data = 32'hDEADBEEF;
    ld_req = 1; ld_addr = 32'h200; ld_size = 2'b10; ld_signed = 0;
    if_req = 1; if_addr = 32'h100;
    run_until_done(2, 20, e);
    tests_run++; if (e !== 5 || other_done !== 1'b0) begin tests_failed++; $display("FAIL prio_store_first: got %0d/%b expected 5/0", e, other_done); end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (d_tr[k+1] !== exp_b[k] || w_tr[k+1] !== 1'b1 || a_tr[k+1] !== 17'h200 + AW'(k) || ram[17'h200 + AW'(k)] !== exp_b[k]) begin
        tests_failed++; $display("FAIL prio_store_byte%0d: got %h/%b/%h expected %h/1/%h", k, d_tr[k+1], w_tr[k+1], a_tr[k+1], exp_b[k], 17'h200 + AW'(k));
      end
    end
    tests_run++; if (w_tr[5] !== 1'b0) begin tests_failed++; $display("FAIL prio_store_done_wr: got %b expected 0", w_tr[5]); end
    run_until_done(1, 20, e);
    tests_run++; if (e !== 6 || other_done !== 1'b0) begin tests_failed++; $display("FAIL prio_load_second: got %0d/%b expected 6/0", e, other_done); end
    tests_run++; if (ld_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL prio_load_data: got %h expected deadbeef", ld_data); end
    run_until_done(0, 20, e);
    tests_run++; if (e !== 6 || if_data !== 32'h00000513) begin tests_failed++; $display("FAIL prio_fetch_third: got %0d/%h expected 6/00000513", e, if_data); end
    tick();
  endtask

  task automatic test_load_extend();
    int e;
    poke(17'h10, 8'h80); poke(17'h20, 8'h34); poke(17'h21, 8'h92);
    ld_req = 1; ld_addr = 32'h10; ld_size = 2'b00; ld_signed = 1; rollback = 1;
    tick();
    tests_run++; if (is_idle !== 1'b1) begin tests_failed++; $display("FAIL rollback_blocks_grant: got %b expected 1", is_idle); end
    rollback = 0;
    run_until_done(1, 20, e);
    tests_run++; if (e !== 3 || ld_data !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL ld_byte_signed: got %0d/%h expected 3/ffffff80", e, ld_data); end
    tick();
    ld_req = 1; ld_signed = 0;
    run_until_done(1, 20, e);
    tests_run++; if (e !== 3 || ld_data !== 32'h00000080) begin tests_failed++; $display("FAIL ld_byte_unsigned: got %0d/%h expected 3/00000080", e, ld_data); end
    tick();
    ld_req = 1; ld_addr = 32'h20; ld_size = 2'b01; ld_signed = 1;
    run_until_done(1, 20, e);
    tests_run++; if (e !== 4 || ld_data !== 32'hFFFF9234) begin tests_failed++; $display("FAIL ld_half_signed: got %0d/%h expected 4/ffff9234", e, ld_data); end
    tick();
  endtask

  task automatic test_rollback();
    int got;
    logic seen;
    ld_req = 1; ld_addr = 32'h200; ld_size = 2'b10; ld_signed = 0;
    repeat (4) tick();
    rollback = 1; ld_req = 0;
    tick();
    tests_run++; if (is_idle !== 1'b1 || ld_done !== 1'b0) begin tests_failed++; $display("FAIL rb_load_flush: got idle=%b done=%b expected 1/0", is_idle, ld_done); end
    rollback = 0;
    seen = 1'b0;
    repeat (8) begin tick(); if (ld_done) seen = 1'b1; end
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL rb_load_no_done: got %b expected 0", seen); end
    st_req = 1; st_addr = 32'h300; st_size = 2'b10; st_data = 32'h11223344;
    repeat (4) tick();
    rollback = 1;
    tick();
    rollback = 0;
    got = -1;
    for (int n = 5; n <= 12; n++) begin
      if (st_done) begin got = n - 1; break; end
      tick();
    end
    st_req = 0;
    tests_run++; if (got !== 5) begin tests_failed++; $display("FAIL rb_store_done: got %0d expected 5", got); end
    tests_run++;
    if ({ram[17'h303], ram[17'h302], ram[17'h301], ram[17'h300]} !== 32'h11223344) begin
      tests_failed++; $display("FAIL rb_store_ram: got %h expected 11223344", {ram[17'h303], ram[17'h302], ram[17'h301], ram[17'h300]});
    end
    tick();
  endtask

  task automatic test_stall();
    int got;
    logic bad_wr;
    if_req = 1; if_addr = 32'h100;
    repeat (4) tick();
    rdy_in = 0;
    bad_wr = 1'b0;
    repeat (3) begin tick(); if (mem_wr !== 1'b0) bad_wr = 1'b1; end
    tests_run++; if (mem_a !== 17'h102) begin tests_failed++; $display("FAIL stall_frozen_addr: got %h expected 00102", mem_a); end
    rdy_in = 1;
    #1;
    tests_run++; if (mem_a !== 17'h101) begin tests_failed++; $display("FAIL stall_replay_addr: got %h expected 00101", mem_a); end
    got = -1;
    for (int n = 7; n <= 16; n++) begin
      tick();
      if (if_done) begin got = n; break; end
    end
    if_req = 0;
    tests_run++; if (got !== 10 || if_data !== 32'h00000513) begin tests_failed++; $display("FAIL stall_fetch: got %0d/%h expected 10/00000513", got, if_data); end
    tick();
    st_req = 1; st_addr = 32'h400; st_size = 2'b10; st_data = 32'hCAFEF00D;
    repeat (3) tick();
    rdy_in = 0;
    #1;
    if (mem_wr !== 1'b0) bad_wr = 1'b1;
    repeat (2) begin tick(); if (mem_wr !== 1'b0) bad_wr = 1'b1; end
    tests_run++; if (bad_wr !== 1'b0) begin tests_failed++; $display("FAIL stall_mem_wr: got %b expected 0", bad_wr); end
    rdy_in = 1;
    got = -1;
    for (int n = 5; n <= 14; n++) begin
      tick();
      if (st_done) begin got = n; break; end
    end
    st_req = 0;
    tests_run++; if (got !== 8) begin tests_failed++; $display("FAIL stall_store_latency: got %0d expected 8", got); end
    tests_run++;
    if ({ram[17'h403], ram[17'h402], ram[17'h401], ram[17'h400]} !== 32'hCAFEF00D) begin
      tests_failed++; $display("FAIL stall_store_ram: got %h expected cafef00d", {ram[17'h403], ram[17'h402], ram[17'h401], ram[17'h400]});
    end
    tick();
  endtask

  task automatic test_wrap();
    int e;
    poke(17'h1, 8'h5A);
    st_req = 1; st_addr = 32'h1FFFF; st_size = 2'b01; st_data = 32'h1234ABCD;
    run_until_done(2, 20, e);
    tests_run++; if (e !== 3 || a_tr[1] !== 17'h1FFFF || a_tr[2] !== 17'h0) begin tests_failed++; $display("FAIL wrap_store: got %0d/%h/%h expected 3/1ffff/00000", e, a_tr[1], a_tr[2]); end
    tests_run++; if ({ram[17'h1], ram[17'h0], ram[17'h1FFFF]} !== 24'h5AABCD) begin tests_failed++; $display("FAIL wrap_ram: got %h expected 5aabcd", {ram[17'h1], ram[17'h0], ram[17'h1FFFF]}); end
    tick();
    ld_req = 1; ld_addr = 32'h1FFFF; ld_size = 2'b01; ld_signed = 0;
    run_until_done(1, 20, e);
    tests_run++; if (e !== 4 || ld_data !== 32'h0000ABCD) begin tests_failed++; $display("FAIL wrap_load: got %0d/%h expected 4/0000abcd", e, ld_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic seen;
    ld_req = 1; ld_addr = 32'h200; ld_size = 2'b10;
    repeat (3) tick();
    rst_in = 1; ld_req = 0;
    tick();
    rst_in = 0;
    tests_run++; if (is_idle !== 1'b1 || mem_a !== 17'h0) begin tests_failed++; $display("FAIL reset_mid_state: got %b/%h expected 1/00000", is_idle, mem_a); end
    seen = 1'b0;
    repeat (8) begin tick(); if (ld_done) seen = 1'b1; end
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_no_done: got %b expected 0", seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_load_extend();
    test_rollback();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
